// File: rtl/wb_xact_capture_pkg.sv
// rtl/wb_xact_capture_pkg.sv - shared types and constants for the Wishbone transfer capture stage
package wb_xact_capture_pkg;

    typedef enum logic {
        XACT_READ  = 1'b0,
        XACT_WRITE = 1'b1
    } xact_dir_e;

    localparam int OVF_CNT_WIDTH = 16;

endpackage

// File: rtl/wb_xact_fifo.sv
// rtl/wb_xact_fifo.sv - record FIFO with extended pointers, combinational head read and same-cycle push/pop
module wb_xact_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   clear,
    input  logic                   push,
    input  logic                   pop,
    input  logic [WIDTH-1:0]       wdata,
    output logic [WIDTH-1:0]       rdata,
    output logic                   empty,
    output logic                   full,
    output logic [$clog2(DEPTH):0] count
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW:0]      wptr;
    logic [AW:0]      rptr;
    logic             do_push;
    logic             do_pop;

    assign empty   = (wptr == rptr);
    assign full    = (wptr[AW] != rptr[AW]) && (wptr[AW-1:0] == rptr[AW-1:0]);
    assign do_pop  = pop && !empty;
    // A pop on the same edge frees the slot the push lands in.
    assign do_push = push && (!full || do_pop);
    assign count   = wptr - rptr;
    assign rdata   = empty ? '0 : mem[rptr[AW-1:0]];

    always_ff @(posedge clk) begin
        if (rst || clear) begin
            wptr <= '0;
            rptr <= '0;
        end else begin
            if (do_push) wptr <= wptr + 1'b1;
            if (do_pop)  rptr <= rptr + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push && !rst && !clear) mem[wptr[AW-1:0]] <= wdata;
    end

endmodule

// File: rtl/wb_xact_capture.sv
// rtl/wb_xact_capture.sv - Wishbone completed-transfer capture into a FIFO stream; option WB_XACT_CAPTURE_TIMESTAMP_EN adds per-record timestamps
module wb_xact_capture
    import wb_xact_capture_pkg::*;
#(
    parameter int WB_ADDR_WIDTH = 32,
    parameter int WB_DATA_WIDTH = 32,
    parameter int DEPTH         = 16,
    parameter int TS_WIDTH      = 32
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       en,
    input  logic                       clear,
    input  logic                       mon_cyc,
    input  logic                       mon_stb,
    input  logic                       mon_ack,
    input  logic                       mon_we,
    input  logic [WB_ADDR_WIDTH-1:0]   mon_adr,
    input  logic [WB_DATA_WIDTH-1:0]   mon_dat_w,
    input  logic [WB_DATA_WIDTH-1:0]   mon_dat_r,
    output logic                       xact_valid,
    input  logic                       xact_ready,
    output logic                       xact_we,
    output logic [WB_ADDR_WIDTH-1:0]   xact_adr,
    output logic [WB_DATA_WIDTH-1:0]   xact_dat,
`ifdef WB_XACT_CAPTURE_TIMESTAMP_EN
    output logic [TS_WIDTH-1:0]        xact_ts,
`endif
    output logic [$clog2(DEPTH+1)-1:0] count,
    output logic [OVF_CNT_WIDTH-1:0]   ovf_cnt
);

`ifdef WB_XACT_CAPTURE_TIMESTAMP_EN
    localparam int TS_BITS = TS_WIDTH;
`else
    localparam int TS_BITS = TS_WIDTH * 0;
`endif
    localparam int BASE_W = 1 + WB_ADDR_WIDTH + WB_DATA_WIDTH;
    localparam int REC_W  = BASE_W + TS_BITS;

    xact_dir_e                  dir;
    logic                       event_hit;
    logic                       push;
    logic                       pop_fire;
    logic                       empty;
    logic                       full;
    logic [WB_DATA_WIDTH-1:0]   cap_dat;
    logic [REC_W-1:0]           wrec;
    logic [REC_W-1:0]           rrec;
    logic [OVF_CNT_WIDTH-1:0]   ovf_q;

    assign dir       = xact_dir_e'(mon_we);
    assign cap_dat   = (dir == XACT_WRITE) ? mon_dat_w : mon_dat_r;
    assign event_hit = en && mon_cyc && mon_stb && mon_ack;
    assign push      = event_hit && !clear;
    assign pop_fire  = xact_valid && xact_ready;

`ifdef WB_XACT_CAPTURE_TIMESTAMP_EN
    logic [TS_WIDTH-1:0] ts_cnt;

    // Free-running; clear deliberately leaves it alone so traces stay monotonic.
    always_ff @(posedge clk) begin
        if (rst) ts_cnt <= '0;
        else     ts_cnt <= ts_cnt + 1'b1;
    end

    assign wrec    = {ts_cnt, mon_we, mon_adr, cap_dat};
    assign xact_ts = rrec[REC_W-1:BASE_W];
`else
    assign wrec = {mon_we, mon_adr, cap_dat};
`endif

    wb_xact_fifo #(
        .WIDTH (REC_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .clear (clear),
        .push  (push),
        .pop   (xact_ready),
        .wdata (wrec),
        .rdata (rrec),
        .empty (empty),
        .full  (full),
        .count (count)
    );

    assign xact_valid = !empty;
    assign xact_we    = rrec[BASE_W-1];
    assign xact_adr   = rrec[WB_ADDR_WIDTH+WB_DATA_WIDTH-1:WB_DATA_WIDTH];
    assign xact_dat   = rrec[WB_DATA_WIDTH-1:0];

    always_ff @(posedge clk) begin
        if (rst || clear) begin
            ovf_q <= '0;
        end else if (push && full && !pop_fire && (ovf_q != '1)) begin
            ovf_q <= ovf_q + 1'b1;
        end
    end

    assign ovf_cnt = ovf_q;

endmodule

// File: tb/tb_wb_xact_capture.sv
// tb/tb_wb_xact_capture.sv - scoreboard bench for wb_xact_capture
module tb_wb_xact_capture;

    localparam int AW    = 32;
    localparam int DW    = 32;
    localparam int DEPTH = 16;
    localparam int TSW   = 32;

    logic          clk = 1'b0;
    logic          rst, en, clear;
    logic          mon_cyc, mon_stb, mon_ack, mon_we;
    logic [AW-1:0] mon_adr;
    logic [DW-1:0] mon_dat_w, mon_dat_r;
    logic          xact_valid, xact_ready, xact_we;
    logic [AW-1:0] xact_adr;
    logic [DW-1:0] xact_dat;
`ifdef WB_XACT_CAPTURE_TIMESTAMP_EN
    logic [TSW-1:0] xact_ts;
`endif
    logic [4:0]    count;
    logic [15:0]   ovf_cnt;

    always #5 clk = ~clk;

    wb_xact_capture #(
        .WB_ADDR_WIDTH (AW),
        .WB_DATA_WIDTH (DW),
        .DEPTH         (DEPTH),
        .TS_WIDTH      (TSW)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .en         (en),
        .clear      (clear),
        .mon_cyc    (mon_cyc),
        .mon_stb    (mon_stb),
        .mon_ack    (mon_ack),
        .mon_we     (mon_we),
        .mon_adr    (mon_adr),
        .mon_dat_w  (mon_dat_w),
        .mon_dat_r  (mon_dat_r),
        .xact_valid (xact_valid),
        .xact_ready (xact_ready),
        .xact_we    (xact_we),
        .xact_adr   (xact_adr),
        .xact_dat   (xact_dat),
`ifdef WB_XACT_CAPTURE_TIMESTAMP_EN
        .xact_ts    (xact_ts),
`endif
        .count      (count),
        .ovf_cnt    (ovf_cnt)
    );

    typedef struct {
        logic           we;
        logic [AW-1:0]  adr;
        logic [DW-1:0]  dat;
        logic [TSW-1:0] ts;
    } rec_t;

    int             checks = 0;
    int             errors = 0;
    rec_t           sb[$];
    int             ovf_m  = 0;
    logic [TSW-1:0] ts_m   = '0;
    logic [TSW-1:0] popped_ts[$];

    task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    // Advance one clock: update the scoreboard from the inputs the DUT will sample, then compare.
    task automatic tick();
        rec_t r;
        bit   ev;
        bit   pop;
        ev  = en && mon_cyc && mon_stb && mon_ack;
        pop = (sb.size() != 0) && xact_ready;
        if (rst || clear) begin
            sb.delete();
            ovf_m = 0;
        end else begin
            if (pop) begin
                r = sb.pop_front();
                check("pop_we", xact_we, r.we);
                check("pop_adr", xact_adr, r.adr);
                check("pop_dat", xact_dat, r.dat);
`ifdef WB_XACT_CAPTURE_TIMESTAMP_EN
                check("pop_ts", xact_ts, r.ts);
                popped_ts.push_back(xact_ts);
`endif
            end
            if (ev) begin
                if (sb.size() < DEPTH) begin
                    r.we  = mon_we;
                    r.adr = mon_adr;
                    r.dat = mon_we ? mon_dat_w : mon_dat_r;
                    r.ts  = ts_m;
                    sb.push_back(r);
                end else if (ovf_m < 65535) begin
                    ovf_m++;
                end
            end
        end
        ts_m = rst ? '0 : ts_m + 1'b1;
        @(posedge clk);
        #1;
        check("valid", xact_valid, sb.size() != 0);
        check("count", count, sb.size());
        check("ovf_cnt", ovf_cnt, ovf_m);
    endtask

    task automatic bus(input logic we, input logic [AW-1:0] adr, input logic [DW-1:0] dw, input logic [DW-1:0] dr);
        mon_cyc = 1'b1; mon_stb = 1'b1; mon_ack = 1'b1;
        mon_we = we; mon_adr = adr; mon_dat_w = dw; mon_dat_r = dr;
    endtask

    task automatic idle();
        mon_cyc = 1'b0; mon_stb = 1'b0; mon_ack = 1'b0;
        mon_we = 1'b0; mon_adr = '0; mon_dat_w = '0; mon_dat_r = '0;
    endtask

    initial begin
        rst = 1'b1; en = 1'b0; clear = 1'b0; xact_ready = 1'b1;
        idle();
        repeat (3) tick();
        rst = 1'b0;
        tick();
        check("rst_we", xact_we, 1'b0);
        check("rst_adr", xact_adr, 32'h0);
        check("rst_dat", xact_dat, 32'h0);

        // Single write, then single read with a distracting DAT_W.
        en = 1'b1;
        bus(1'b1, 32'h1000, 32'hA5A5_A5A5, 32'h0);
        tick();
        idle();
        check("wr_adr", xact_adr, 32'h1000);
        check("wr_dat", xact_dat, 32'hA5A5_A5A5);
        tick(); tick();
        bus(1'b0, 32'h20, 32'hDEAD, 32'h1234_5678);
        tick();
        idle();
        check("rd_we", xact_we, 1'b0);
        check("rd_dat", xact_dat, 32'h1234_5678);
        tick(); tick();

        // 20 back-to-back ACKs with no consumer.
        xact_ready = 1'b0;
        for (int i = 0; i < 20; i++) begin
            bus(i[0], 32'h100 + i, $urandom, $urandom);
            tick();
        end
        idle();
        tick();
        check("full_count", count, 5'd16);
        check("full_ovf", ovf_cnt, 16'd4);

        // Push and pop on the same edge while full.
        xact_ready = 1'b1;
        bus(1'b1, 32'hBEEF, 32'hCAFE_F00D, 32'h0);
        tick();
        idle();
        xact_ready = 1'b0;
        tick();
        check("pp_count", count, 5'd16);
        check("pp_ovf", ovf_cnt, 16'd4);
        xact_ready = 1'b1;
        for (int i = 0; i < 20 && sb.size() != 0; i++) tick();
        check("drained", sb.size(), 0);

        // Clear with a concurrent ACK while five records are held.
        xact_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            bus(1'b0, 32'h200 + i, 32'h0, 32'h5000 + i);
            tick();
        end
        bus(1'b1, 32'h300, 32'h77, 32'h0);
        clear = 1'b1;
        tick();
        clear = 1'b0;
        idle();
        check("clr_count", count, 5'd0);
        check("clr_ovf", ovf_cnt, 16'd0);
        check("clr_valid", xact_valid, 1'b0);

        // Disabled capture ignores the bus.
        en = 1'b0;
        bus(1'b1, 32'h400, 32'h1, 32'h0);
        tick();
        idle();
        check("en0_valid", xact_valid, 1'b0);
        en = 1'b1;

        // Timestamped ACKs at cycles 10 and 13 after reset.
        rst = 1'b1;
        tick();
        rst = 1'b0;
        repeat (9) tick();
        bus(1'b1, 32'h10, 32'h10, 32'h0);
        tick();
        idle();
        repeat (2) tick();
        bus(1'b1, 32'h13, 32'h13, 32'h0);
        tick();
        idle();
        popped_ts.delete();
        xact_ready = 1'b1;
        tick(); tick();
`ifdef WB_XACT_CAPTURE_TIMESTAMP_EN
        check("ts_n", popped_ts.size(), 2);
        if (popped_ts.size() == 2) check("ts_delta", popped_ts[1] - popped_ts[0], 32'd3);
`endif

        // Reset in the middle of a drain.
        xact_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            bus(1'b0, 32'h500 + i, 32'h0, 32'h600 + i);
            tick();
        end
        idle();
        xact_ready = 1'b1;
        tick();
        rst = 1'b1;
        tick();
        check("rst_mid_valid", xact_valid, 1'b0);
        rst = 1'b0;
        tick(); tick();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
